// File: rtl/pifo_pkg.sv
// Shared definitions for the pipelined priority encoder: size derivation
// helpers and the tree node type at the default encode width.
package pifo_pkg;

  // Ceiling log2 for elaboration-time sizing (returns 0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width of the zero-padded request vector feeding the tree.
  function automatic int pot_width(input int log_width);
    return 1 << log_width;
  endfunction

  // Number of register stages when the tree is cut every stage_levels levels.
  function automatic int num_stages(input int log_width, input int stage_levels);
    return (log_width + stage_levels - 1) / stage_levels;
  endfunction

  localparam int LOG_WIDTH  = 10;
  localparam int POT_WIDTH  = pot_width(LOG_WIDTH);
  localparam int NUM_STAGES = num_stages(LOG_WIDTH, 2);

  // One tree node: whether any request below it is set, and the index of
  // the winner below it (0 when nothing is set).
  typedef struct packed {
    logic                 hit;
    logic [LOG_WIDTH-1:0] idx;
  } node_t;

endpackage

// File: rtl/priority_encode_level.sv
// One level of the priority tree: merges adjacent (hit, idx) pairs into
// half as many parent nodes. Indices are carried at full log_width so
// every level has the same node shape; bit `level` records which child won.
module priority_encode_level
  import pifo_pkg::*;
#(
  parameter int log_width = 10,
  parameter int level     = 0,
  parameter bit msb_first = 1'b0,
  localparam int n_in     = pot_width(log_width) >> level,
  localparam int n_out    = n_in / 2
) (
  input  logic [n_in-1:0]                 in_hit,
  input  logic [n_in-1:0][log_width-1:0]  in_idx,
  output logic [n_out-1:0]                out_hit,
  output logic [n_out-1:0][log_width-1:0] out_idx
);

  localparam logic [log_width-1:0] level_bit = log_width'(1) << level;

  // Pick the preferred child that has a hit; an empty pair encodes as 0.
  always_comb begin
    out_hit = '0;
    out_idx = '0;
    for (int j = 0; j < n_out; j++) begin
      out_hit[j] = in_hit[2*j] | in_hit[2*j+1];
      if (msb_first) begin
        if (in_hit[2*j+1])   out_idx[j] = in_idx[2*j+1] | level_bit;
        else if (in_hit[2*j]) out_idx[j] = in_idx[2*j];
      end else begin
        if (in_hit[2*j])        out_idx[j] = in_idx[2*j];
        else if (in_hit[2*j+1]) out_idx[j] = in_idx[2*j+1] | level_bit;
      end
    end
  end

endmodule

// File: rtl/priority_encode_pipe.sv
// Pipelined log-tree priority encoder. The tree is built from one
// priority_encode_level per level; a register stage closes every
// stage_levels levels (and after the final level).
//
// Handshake: a transfer happens on a clock edge where valid && ready are
// both high. Each stage s holds one entry (vld[s]) and is ready when it is
// empty or the stage after it is ready, so bubbles collapse; a stage loads
// whenever it is ready, and holds data and tag while full and blocked.
module priority_encode_pipe
  import pifo_pkg::*;
#(
  parameter int width        = 1024,
  parameter int log_width    = 10,
  parameter int stage_levels = 2,
  parameter bit msb_first    = 1'b0,
  parameter int tag_width    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [width-1:0]     in_decode,
  input  logic [tag_width-1:0] in_tag,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [log_width-1:0] out_encode,
  output logic                 out_hit,
  output logic [tag_width-1:0] out_tag
);

  localparam int pot = pot_width(log_width);
  localparam int ns  = num_stages(log_width, stage_levels);

  logic [ns-1:0]        vld;
  logic [ns:0]          rdy;
  logic [ns-1:0]        src_vld;
  logic [ns-1:0]        cap;
  logic [tag_width-1:0] tag_q   [ns];
  logic [tag_width-1:0] tag_src [ns];
  logic [pot-1:0]       leaf_hit;

  // Pad the request vector with zeros up to the tree width.
  if (pot == width) begin : g_nopad
    assign leaf_hit = in_decode;
  end else begin : g_pad
    assign leaf_hit = {{(pot-width){1'b0}}, in_decode};
  end

  // Ready chain, flattened: stage s is blocked only when it and every stage
  // after it are full and the output is not being taken.
  always_comb begin
    logic full;
    full    = 1'b1;
    rdy     = '0;
    rdy[ns] = out_rdy;
    for (int s = 0; s < ns; s++) begin
      full = 1'b1;
      for (int k = s; k < ns; k++) full = full & vld[k];
      rdy[s] = out_rdy | ~full;
    end
  end

  // Upstream valid/tag for each stage and the data capture enables.
  always_comb begin
    src_vld    = '0;
    src_vld[0] = in_vld;
    for (int s = 1; s < ns; s++) src_vld[s] = vld[s-1];
    tag_src[0] = in_tag;
    for (int s = 1; s < ns; s++) tag_src[s] = tag_q[s-1];
    cap = rdy[ns-1:0] & src_vld;
  end

  // Stage occupancy: a ready stage takes whatever its upstream offers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      for (int s = 0; s < ns; s++)
        if (rdy[s]) vld[s] <= src_vld[s];
    end
  end

  // Sideband tags travel in lockstep with their stage's data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < ns; s++) tag_q[s] <= '0;
    end else begin
      for (int s = 0; s < ns; s++)
        if (cap[s]) tag_q[s] <= tag_src[s];
    end
  end

  for (genvar l = 0; l < log_width; l++) begin : g_lvl
    localparam int  n_in     = pot >> l;
    localparam int  n_out    = n_in / 2;
    localparam int  stg      = l / stage_levels;
    localparam bit  boundary = ((l % stage_levels) == (stage_levels - 1)) ||
                               (l == log_width - 1);

    logic [n_in-1:0]                 src_hit;
    logic [n_in-1:0][log_width-1:0]  src_idx;
    logic [n_out-1:0]                c_hit;
    logic [n_out-1:0][log_width-1:0] c_idx;
    logic [n_out-1:0]                q_hit;
    logic [n_out-1:0][log_width-1:0] q_idx;

    if (l == 0) begin : g_src_leaf
      assign src_hit = leaf_hit;
      assign src_idx = '0;
    end else begin : g_src_prev
      assign src_hit = g_lvl[l-1].q_hit;
      assign src_idx = g_lvl[l-1].q_idx;
    end

    priority_encode_level #(
      .log_width (log_width),
      .level     (l),
      .msb_first (msb_first)
    ) u_level (
      .in_hit  (src_hit),
      .in_idx  (src_idx),
      .out_hit (c_hit),
      .out_idx (c_idx)
    );

    if (boundary) begin : g_reg
      // Stage register: captures partial results only when its stage loads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_hit <= '0;
          q_idx <= '0;
        end else if (cap[stg]) begin
          q_hit <= c_hit;
          q_idx <= c_idx;
        end
      end
    end else begin : g_wire
      assign q_hit = c_hit;
      assign q_idx = c_idx;
    end
  end

  assign in_rdy     = rdy[0];
  assign out_vld    = vld[ns-1];
  assign out_hit    = g_lvl[log_width-1].q_hit[0];
  assign out_encode = g_lvl[log_width-1].q_idx[0];
  assign out_tag    = tag_q[ns-1];

endmodule

// File: tb/tb_priority_encode_pipe.sv
// Bench for priority_encode_pipe. Four instances share one stimulus stream:
//   0: width 1024, 2 levels/stage, lsb   (5 stages)
//   1: width 1024, 2 levels/stage, msb   (5 stages)
//   2: width 1000, 3 levels/stage, lsb   (4 stages)
//   3: width 1000, 3 levels/stage, msb   (4 stages)
// Each instance has its own expected queue filled from a bit-scan model.
module tb_priority_encode_pipe;

  localparam int EW = 51;  // {accept edge[31:0], tag[7:0], hit, encode[9:0]}

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          out_rdy;
  logic [1023:0] in_decode;
  logic [7:0]    in_tag;

  logic       in_rdy     [4];
  logic       out_vld    [4];
  logic       out_hit    [4];
  logic [9:0] out_encode [4];
  logic [7:0] out_tag    [4];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_low;
  int acc_cnt [4];
  bit held [4];
  logic [19:0] prev_out [4];

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  logic [EW-1:0] exp_q3[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  priority_encode_pipe #(.width(1024), .log_width(10), .stage_levels(2), .msb_first(1'b0), .tag_width(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy[0]), .in_decode(in_decode), .in_tag(in_tag),
    .out_vld(out_vld[0]), .out_rdy(out_rdy), .out_encode(out_encode[0]), .out_hit(out_hit[0]), .out_tag(out_tag[0]));
  priority_encode_pipe #(.width(1024), .log_width(10), .stage_levels(2), .msb_first(1'b1), .tag_width(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy[1]), .in_decode(in_decode), .in_tag(in_tag),
    .out_vld(out_vld[1]), .out_rdy(out_rdy), .out_encode(out_encode[1]), .out_hit(out_hit[1]), .out_tag(out_tag[1]));
  priority_encode_pipe #(.width(1000), .log_width(10), .stage_levels(3), .msb_first(1'b0), .tag_width(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy[2]), .in_decode(in_decode[999:0]), .in_tag(in_tag),
    .out_vld(out_vld[2]), .out_rdy(out_rdy), .out_encode(out_encode[2]), .out_hit(out_hit[2]), .out_tag(out_tag[2]));
  priority_encode_pipe #(.width(1000), .log_width(10), .stage_levels(3), .msb_first(1'b1), .tag_width(8)) u_dut3 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy[3]), .in_decode(in_decode[999:0]), .in_tag(in_tag),
    .out_vld(out_vld[3]), .out_rdy(out_rdy), .out_encode(out_encode[3]), .out_hit(out_hit[3]), .out_tag(out_tag[3]));

  function automatic int width_of(input int k);
    return (k < 2) ? 1024 : 1000;
  endfunction

  function automatic bit msb_of(input int k);
    return (k % 2) == 1;
  endfunction

  function automatic int ns_of(input int k);
    return (k < 2) ? 5 : 4;
  endfunction

  // Reference: scan the first w bits; keep the first hit (lsb) or the last (msb).
  function automatic logic [10:0] ref_encode(input logic [1023:0] v, input int w, input bit msb);
    logic [10:0] r;
    r = '0;
    for (int i = 0; i < w; i++)
      if (v[i] && (msb || !r[10])) r = {1'b1, 10'(i)};
    return r;
  endfunction

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] r;
    r = '0;
    case ($urandom_range(0, 4))
      0: r = '0;
      1: r[$urandom_range(0, 1023)] = 1'b1;
      2: begin
        r[$urandom_range(0, 1023)] = 1'b1;
        r[$urandom_range(0, 1023)] = 1'b1;
      end
      3: for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
      default: for (int i = 0; i < 3; i++) r[$urandom_range(960, 1023)] = 1'b1;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: result with no outstanding request", name);
  endtask

  task automatic q_push(input int k, input logic [EW-1:0] e);
    case (k)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      2: exp_q2.push_back(e);
      default: exp_q3.push_back(e);
    endcase
  endtask

  function automatic int q_size(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  task automatic q_pop(input int k, output logic [EW-1:0] e, output bit ok);
    e  = '0;
    ok = (q_size(k) != 0);
    if (ok) begin
      case (k)
        0: e = exp_q0.pop_front();
        1: e = exp_q1.pop_front();
        2: e = exp_q2.pop_front();
        default: e = exp_q3.pop_front();
      endcase
    end
  endtask

  task automatic q_clear();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    exp_q3.delete();
  endtask

  // scoreboard: sampled mid-cycle; edge_n is the edge the handshakes complete on
  int            edge_n;
  logic [19:0]   cur;
  logic [EW-1:0] e;
  bit            ok;

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) held[k] = 1'b0;
    end else begin
      edge_n = cyc + 1;
      if (!out_rdy) last_low = edge_n;
      for (int k = 0; k < 4; k++) begin
        cur = {out_vld[k], out_hit[k], out_encode[k], out_tag[k]};
        if (held[k]) check($sformatf("hold_dut%0d", k), 64'(cur), 64'(prev_out[k]));
        if (out_vld[k] && out_rdy) begin
          q_pop(k, e, ok);
          if (!ok) fail_now($sformatf("unexpected_dut%0d", k));
          else begin
            check($sformatf("result_dut%0d", k),
                  64'({out_hit[k], out_encode[k], out_tag[k]}),
                  64'({e[10], e[9:0], e[18:11]}));
            if (last_low < int'(e[50:19]))
              check($sformatf("latency_dut%0d", k), 64'(edge_n - int'(e[50:19])), 64'(ns_of(k)));
          end
        end
        if (in_vld && in_rdy[k]) begin
          q_push(k, {32'(edge_n), in_tag, ref_encode(in_decode, width_of(k), msb_of(k))});
          acc_cnt[k]++;
        end
        held[k]     = out_vld[k] && !out_rdy;
        prev_out[k] = cur;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1023:0] v, input logic [7:0] t);
    in_decode = v;
    in_tag    = t;
    in_vld    = 1'b1;
    step();
    in_vld    = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      in_decode = rand_vec();
      in_tag    = 8'($urandom);
      in_vld    = 1'b1;
      step();
    end
    in_vld = 1'b0;
  endtask

  initial begin
    logic [1023:0] v;
    int a0, a2;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1; in_decode = '0; in_tag = '0;
    last_low = 0;
    for (int k = 0; k < 4; k++) begin acc_cnt[k] = 0; held[k] = 1'b0; prev_out[k] = '0; end

    // pin the model with hand-derived values
    v = '0; v[5] = 1'b1; v[700] = 1'b1;
    check("model_lsb_5_700", 64'(ref_encode(v, 1024, 1'b0)), 64'({1'b1, 10'd5}));
    check("model_msb_5_700", 64'(ref_encode(v, 1024, 1'b1)), 64'({1'b1, 10'd700}));
    v = '1;
    check("model_ones_w1000_msb", 64'(ref_encode(v, 1000, 1'b1)), 64'({1'b1, 10'd999}));
    check("model_ones_w1024_lsb", 64'(ref_encode(v, 1024, 1'b0)), 64'({1'b1, 10'd0}));

    repeat (3) step();
    for (int k = 0; k < 4; k++)
      check($sformatf("reset_outputs_dut%0d", k),
            64'({out_vld[k], out_hit[k], out_encode[k], out_tag[k]}), 64'(0));
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("in_rdy_after_reset_dut%0d", k), 64'(in_rdy[k]), 64'(1));
    repeat (2) step();

    // bits 5 and 700; result sits on the output in the cycle ending at edge t+NS
    v = '0; v[5] = 1'b1; v[700] = 1'b1;
    send(v, 8'h11);
    repeat (3) step();
    check("w1000_lsb_5_700", 64'({out_vld[2], out_hit[2], out_encode[2]}), 64'({1'b1, 1'b1, 10'd5}));
    check("w1000_msb_5_700", 64'({out_vld[3], out_hit[3], out_encode[3]}), 64'({1'b1, 1'b1, 10'd700}));
    check("w1024_not_early", 64'(out_vld[0]), 64'(0));
    step();
    check("w1024_lsb_5_700", 64'({out_vld[0], out_hit[0], out_encode[0], out_tag[0]}), 64'({1'b1, 1'b1, 10'd5, 8'h11}));
    check("w1024_msb_5_700", 64'({out_vld[1], out_hit[1], out_encode[1]}), 64'({1'b1, 1'b1, 10'd700}));
    repeat (3) step();

    // empty request still carries its tag
    send('0, 8'h3C);
    repeat (4) step();
    check("zero_request", 64'({out_vld[0], out_hit[0], out_encode[0], out_tag[0]}), 64'({1'b1, 1'b0, 10'd0, 8'h3C}));
    repeat (3) step();

    // top bit of the non-power-of-two width
    v = '0; v[999] = 1'b1;
    send(v, 8'h99);
    repeat (3) step();
    check("w1000_lsb_bit999", 64'({out_vld[2], out_hit[2], out_encode[2]}), 64'({1'b1, 1'b1, 10'd999}));
    check("w1000_msb_bit999", 64'({out_vld[3], out_hit[3], out_encode[3]}), 64'({1'b1, 1'b1, 10'd999}));
    repeat (3) step();

    // all ones
    v = '1;
    send(v, 8'hA5);
    repeat (3) step();
    check("w1000_lsb_ones", 64'({out_vld[2], out_hit[2], out_encode[2]}), 64'({1'b1, 1'b1, 10'd0}));
    check("w1000_msb_ones", 64'({out_vld[3], out_hit[3], out_encode[3]}), 64'({1'b1, 1'b1, 10'd999}));
    step();
    check("w1024_lsb_ones", 64'({out_vld[0], out_hit[0], out_encode[0]}), 64'({1'b1, 1'b1, 10'd0}));
    check("w1024_msb_ones", 64'({out_vld[1], out_hit[1], out_encode[1]}), 64'({1'b1, 1'b1, 10'd1023}));
    repeat (4) step();

    // 64 back-to-back requests at full rate
    a0 = acc_cnt[0]; a2 = acc_cnt[2];
    stream(64);
    repeat (8) step();
    check("stream_accepts_dut0", 64'(acc_cnt[0] - a0), 64'(64));
    check("stream_accepts_dut2", 64'(acc_cnt[2] - a2), 64'(64));

    // stall the output for 10 cycles while streaming
    a0 = acc_cnt[0]; a2 = acc_cnt[2];
    out_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_decode = rand_vec(); in_tag = 8'($urandom); in_vld = 1'b1;
      step();
    end
    check("stall_accepts_dut0", 64'(acc_cnt[0] - a0), 64'(5));
    check("stall_accepts_dut2", 64'(acc_cnt[2] - a2), 64'(4));
    check("stall_in_rdy_dut0", 64'(in_rdy[0]), 64'(0));
    check("stall_in_rdy_dut2", 64'(in_rdy[2]), 64'(0));
    out_rdy = 1'b1;
    stream(10);
    repeat (8) step();

    // random valid/ready traffic
    for (int i = 0; i < 400; i++) begin
      in_decode = rand_vec();
      in_tag    = 8'($urandom);
      in_vld    = ($urandom_range(0, 3) != 0);
      out_rdy   = ($urandom_range(0, 3) != 0);
      step();
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    repeat (10) step();

    // reset with the pipelines full and the output stalled
    out_rdy = 1'b0;
    stream(6);
    check("full_before_reset", 64'(out_vld[0]), 64'(1));
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("async_reset_vld_dut%0d", k), 64'(out_vld[k]), 64'(0));
    q_clear();
    step();
    step();
    rst = 1'b0;
    out_rdy = 1'b1;
    repeat (10) step();
    for (int k = 0; k < 4; k++) check($sformatf("no_stale_dut%0d", k), 64'(out_vld[k]), 64'(0));
    v = '0; v[300] = 1'b1; v[301] = 1'b1;
    send(v, 8'h5A);
    repeat (4) step();
    check("post_reset_lsb", 64'({out_vld[0], out_hit[0], out_encode[0], out_tag[0]}), 64'({1'b1, 1'b1, 10'd300, 8'h5A}));
    check("post_reset_msb", 64'({out_vld[1], out_hit[1], out_encode[1]}), 64'({1'b1, 1'b1, 10'd301}));
    repeat (8) step();

    for (int k = 0; k < 4; k++) check($sformatf("drained_dut%0d", k), 64'(q_size(k)), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
